// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding, default operand width and iteration-counter sizing.
package mult_pkg;

  localparam int MULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

  // One extra bit so the counter can reach WIDTH without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mult_seq_8_dp.sv
// Multiplier datapath: multiplicand, accumulator (upper half) and
// multiplier/quotient shift register (lower half) with the conditional add.
module mult_seq_8_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mq_next
);

  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mq_reg;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   mq_shift;

  // The add is WIDTH+1 bits wide with carry-in 0; the carry becomes the
  // new accumulator MSB and the sum LSB shifts into the multiplier register.
  always_comb begin
    addend   = mq_reg[0] ? mcand_reg : '0;
    sum      = {1'b0, acc_reg} + {1'b0, addend};
    acc_next = sum[WIDTH:1];
    mq_shift = {sum[0], mq_reg};
    mq_next  = mq_shift[WIDTH:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg <= '0;
      acc_reg   <= '0;
      mq_reg    <= '0;
    end else if (load) begin
      mcand_reg <= a;
      acc_reg   <= '0;
      mq_reg    <= b;
    end else if (step) begin
      acc_reg <= acc_next;
      mq_reg  <= mq_next;
    end
  end

endmodule

// File: rtl/mult_seq_8.sv
// Sequential unsigned multiplier: one multiplier bit per clock, product and
// zero flag registered on the final iteration, one-cycle done pulse.
module mult_seq_8
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic               zero
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  mult_state_t         state_reg;
  mult_state_t         state_next;
  logic [CW-1:0]       cnt_reg;
  logic [2*WIDTH-1:0]  p_reg;
  logic                zero_reg;
  logic                load;
  logic                step;
  logic                last;
  logic [WIDTH-1:0]    acc_next;
  logic [WIDTH-1:0]    mq_next;
  logic [2*WIDTH-1:0]  product_next;

  mult_seq_8_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .a        (a),
    .b        (b),
    .acc_next (acc_next),
    .mq_next  (mq_next)
  );

  assign product_next = {acc_next, mq_next};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // start is only honoured outside RUN, so a request mid-operation is dropped.
  always_comb begin
    busy = (state_reg == ST_RUN);
    done = (state_reg == ST_DONE);
    load = (state_reg != ST_RUN) && start;
    step = (state_reg == ST_RUN);
    last = step && (cnt_reg == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      p_reg    <= '0;
      zero_reg <= 1'b1;
    end else begin
      if (load) begin
        cnt_reg <= '0;
      end else if (step) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      // The previous product stays visible until the final iteration.
      if (last) begin
        p_reg    <= product_next;
        zero_reg <= (product_next == '0);
      end
    end
  end

  assign p    = p_reg;
  assign zero = zero_reg;

endmodule

// File: tb/tb_mult_seq_8.sv
// Self-checking bench for mult_seq_8: directed products with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_mult_seq_8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;
  logic        zero;

  int n_checks;
  int n_fail;
  bit cmp_en;

  // Behavioural model: cycles left in the current operation, pending product.
  int          m_left;
  logic [15:0] m_pend;
  logic [15:0] m_p;
  logic        m_done;

  mult_seq_8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_p    = 16'd0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0) m_p = m_pend;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pend = {8'd0, a} * {8'd0, b};
        m_left = 8;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("p",    32'(p),    32'(m_p));
      chk("zero", 32'(zero), 32'(m_p == 16'd0));
    end
  end

  // Waits at negedges until done; returns number of cycles waited.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic mul_lit(input logic [7:0] aa, input logic [7:0] bb, input logic [15:0] exp);
    int cyc;
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("latency", 32'(cyc), 32'd8);
    chk("p_lit", 32'(p), 32'(exp));
    chk("zero_lit", 32'(zero), 32'(exp == 16'd0));
    $display("mul a=%0d b=%0d -> p=%0d zero=%0d", aa, bb, p, zero);
  endtask

  initial begin
    int          cyc;
    logic [8:0]  b9;
    bit          saw_done;
    n_checks = 0; n_fail = 0; cmp_en = 1'b0;
    m_left = 0; m_done = 1'b0; m_p = 16'd0; m_pend = 16'd0;
    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_p",    32'(p),    32'd0);
    chk("rst_zero", 32'(zero), 32'd1);

    mul_lit(8'd8, 8'd80, 16'h0280);
    mul_lit(8'd80, 8'd80, 16'h1900);
    b9 = 9'd308;
    mul_lit(8'd208, b9[7:0], 16'h2A40);
    mul_lit(8'd255, 8'd255, 16'hFE01);
    mul_lit(8'd0, 8'd173, 16'h0000);
    mul_lit(8'd91, 8'd0, 16'h0000);

    // start mid-RUN must be ignored
    @(negedge clk);
    a = 8'd12; b = 8'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'd200; b = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("ignored_start_p", 32'(p), 32'd156);
    $display("mid-run start ignored: p=%0d", p);

    // back-to-back: start during DONE
    a = 8'd17; b = 8'd19; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);
    wait_done(cyc);
    chk("b2b_latency", 32'(cyc), 32'd8);
    chk("b2b_p", 32'(p), 32'd323);
    $display("back-to-back: p=%0d after %0d cycles", p, cyc + 1);

    // reset in the middle of an operation
    @(negedge clk);
    a = 8'd99; b = 8'd77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_p",    32'(p),    32'd0);
    chk("midrst_zero", 32'(zero), 32'd1);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("midrst_no_done", 32'(saw_done), 32'd0);
    $display("mid-run reset: p=%0d zero=%0d done_seen=%0d", p, zero, saw_done);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 2) == 0);
      a     = 8'($urandom);
      b     = 8'($urandom);
      @(negedge clk);
      if (done) $display("random op done: p=%0d", p);
    end
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
